// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_resp data-memory responder.
// Holds the FSM state encoding, the data word width and the latency counter width.
package dmem_resp_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_resp_array.sv
// Word array for dmem_resp. Writes are synchronous and reads are combinational.
// The storage is not reset, so its contents are undefined until written.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [WORD_W-1:0]              rd_data
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: accepts one load or store at a time and returns a
// registered response LATENCY cycles later. Define DMEM_RESP_MISALIGN_CHK_EN to fault misaligned requests.
//   state | meaning
//   IDLE  | ready; accepts a request and commits stores on the accept edge
//   BUSY  | latency countdown; request inputs ignored
//   RESP  | one-cycle rsp_valid strobe
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     rd_idx;
  logic              req_bad;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_addr;

  assign req_idx     = req_addr[AW+1:2];
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_RESP_MISALIGN_CHK_EN
  assign req_bad = |req_addr[1:0];
`else
  assign req_bad = 1'b0;
`endif

  dmem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (CLK),
    .wr_en   (arr_we),
    .wr_idx  (req_idx),
    .wr_data (req_wdata),
    .rd_idx  (rd_idx),
    .rd_data (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    arr_we    = 1'b0;
    rd_idx    = idx_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        rd_idx    = req_idx;
        if (req_valid) begin
          we_d   = req_we;
          idx_d  = req_idx;
          bad_d  = req_bad;
          cnt_d  = CNT_LOAD;
          arr_we = req_we & ~req_bad;
          // With single-cycle latency the read data is captured on the accept edge itself
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            rdata_d = (req_we | req_bad) ? '0 : arr_rdata;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
          rdata_d = (we_q | bad_q) ? '0 : arr_rdata;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_rdata = rdata_q;

`ifdef DMEM_RESP_MISALIGN_CHK_EN
  logic err_q, err_d;

  assign err_d = (state_d == ST_RESP) & bad_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a LATENCY=2 instance and a LATENCY=1 instance,
// both with 256 words, checked against hand-computed responses.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v2, we2, rdy2, rv2, er2;
  logic [31:0] a2, wd2, rd2;
  logic        v1, we1, rdy1, rv1, er1;
  logic [31:0] a1, wd1, rd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .req_valid(v2), .req_we(we2), .req_addr(a2),
    .req_wdata(wd2), .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(er2)
  );

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .req_valid(v1), .req_we(we1), .req_addr(a1),
    .req_wdata(wd1), .req_ready(rdy1), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for acceptance and then for the response strobe.
  task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    logic got;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    got   = 1'b0;
    if (sel == 1) begin v1 = 1'b1; we1 = we; a1 = addr; wd1 = wdata; end
    else          begin v2 = 1'b1; we2 = we; a2 = addr; wd2 = wdata; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (sel == 1) ? rdy1 : rdy2;
    end
    @(posedge clk);
    #1;
    if (sel == 1) v1 = 1'b0;
    else          v2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((sel == 1) ? rv1 : rv2) begin
        lat   = k;
        rdata = (sel == 1) ? rd1 : rd2;
        err   = (sel == 1) ? er1 : er2;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [8:0]  rdy_pat, rv_pat;
    logic [31:0] b2b_data [3];
    logic [31:0] b2b_addr [3];
    int          n_acc, n_rsp;
    logic        seen_rv;

    rst_n = 1'b0;
    v2 = 0; we2 = 0; a2 = '0; wd2 = '0;
    v1 = 0; we1 = 0; a1 = '0; wd1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", rdy2, 1'b1);
    check("rst_rsp_valid", rv2, 1'b0);
    check("rst_rdata", rd2, 32'h0);
    check("rst_err", er2, 1'b0);
    check("rst_ready_l1", rdy1, 1'b1);
    rst_n = 1'b1;

    do_req(2, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("store_lat", lat, 2);
    check("store_rdata", rd, 32'h0);
    check("store_err", er, 1'b0);
    do_req(2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("load_lat", lat, 2);
    check("load_rdata", rd, 32'hDEADBEEF);
    check("load_err", er, 1'b0);

    do_req(2, 1'b1, 32'h0, 32'h000000A0, rd, er, lat);
    do_req(2, 1'b1, 32'h4, 32'h000000A4, rd, er, lat);
    do_req(2, 1'b1, 32'h8, 32'h000000A8, rd, er, lat);
    check("preload_lat", lat, 2);

    b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
    n_acc = 0; n_rsp = 0;
    rdy_pat = '0; rv_pat = '0;
    v2 = 1'b1; we2 = 1'b0; a2 = b2b_addr[0]; wd2 = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rdy_pat[i] = rdy2;
      rv_pat[i]  = rv2;
      if (rv2 && n_rsp < 3) begin
        b2b_data[n_rsp] = rd2;
        n_rsp++;
      end
      if (rdy2) begin
        @(posedge clk);
        #1;
        n_acc++;
        if (n_acc < 3) a2 = b2b_addr[n_acc];
        else           v2 = 1'b0;
      end
    end
    v2 = 1'b0;
    check("b2b_ready_pattern", {23'b0, rdy_pat}, {23'b0, 9'b001001001});
    check("b2b_valid_pattern", {23'b0, rv_pat}, {23'b0, 9'b100100100});
    check("b2b_data0", b2b_data[0], 32'h000000A0);
    check("b2b_data1", b2b_data[1], 32'h000000A4);
    check("b2b_data2", b2b_data[2], 32'h000000A8);

    do_req(2, 1'b1, 32'h400, 32'h12345678, rd, er, lat);
    do_req(2, 1'b0, 32'h0, 32'h0, rd, er, lat);
    check("wrap_rdata", rd, 32'h12345678);
    check("wrap_lat", lat, 2);

`ifdef DMEM_RESP_MISALIGN_CHK_EN
    do_req(2, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("mis_load_lat", lat, 2);
    check("mis_load_err", er, 1'b1);
    check("mis_load_rdata", rd, 32'h0);
    @(negedge clk);
    check("mis_err_cleared", er2, 1'b0);
    do_req(2, 1'b1, 32'h11, 32'hFFFFFFFF, rd, er, lat);
    check("mis_store_err", er, 1'b1);
    do_req(2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("mis_store_no_write", rd, 32'hDEADBEEF);
    check("mis_after_err", er, 1'b0);
`else
    do_req(2, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("unaligned_rdata", rd, 32'hDEADBEEF);
    check("unaligned_err", er, 1'b0);
`endif

    v2 = 1'b1; we2 = 1'b0; a2 = 32'h10;
    @(negedge clk);
    check("midrst_ready_before", rdy2, 1'b1);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    @(negedge clk);
    check("midrst_busy", rdy2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", rdy2, 1'b1);
    check("midrst_rdata", rd2, 32'h0);
    seen_rv = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen_rv = seen_rv | rv2;
    end
    // Release reset and present a store to the LATENCY=1 instance on the same negedge
    rst_n = 1'b1;
    v1 = 1'b1; we1 = 1'b1; a1 = 32'h10; wd1 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(negedge clk);
    seen_rv = seen_rv | rv2;
    check("l1_first_edge_rsp", rv1, 1'b1);
    check("l1_store_rdata", rd1, 32'h0);
    check("midrst_after_ready", rdy2, 1'b1);
    check("midrst_after_rdata", rd2, 32'h0);
    check("midrst_after_err", er2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      seen_rv = seen_rv | rv2;
    end
    check("midrst_no_rsp", seen_rv, 1'b0);

    do_req(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("l1_load_lat", lat, 1);
    check("l1_load_rdata", rd, 32'hCAFEF00D);
    check("l1_load_err", er, 1'b0);
    check("l1_busy_in_resp", rdy1, 1'b0);
    @(negedge clk);
    check("l1_ready_back", rdy1, 1'b1);
    check("l1_rsp_done", rv1, 1'b0);
    check("l1_rdata_hold", rd1, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
